// File: rtl/dmem_sram_resp.sv
// Data-memory responder: synchronous 32-bit SRAM with byte-enable writes and one-cycle registered reads.
// Define SRAM_WAIT_STATE_EN to compile in the IDLE/WAIT stall FSM whose latency follows WAIT_CYC.
module dmem_sram_resp #(
  parameter int ADDR_W   = 14,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              fire;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              rvalid_q;
  logic [31:0]       rdata_q;

`ifdef SRAM_WAIT_STATE_EN
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic              accept;

  assign ready_o = (state_q == S_IDLE);
  assign accept  = req_i && ready_o;

  // While stalled the array is driven from the latched request, otherwise straight from the port.
  always_comb begin
    if (state_q == S_WAIT) begin
      fire      = (cnt_q == 4'd0);
      mem_addr  = addr_q;
      mem_be    = we_q;
      mem_wdata = wdata_q;
    end else begin
      fire      = accept && (WAIT_CYC == 0);
      mem_addr  = addr_i;
      mem_be    = we_i;
      mem_wdata = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (WAIT_CYC != 0)) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'(WAIT_CYC - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= addr_i;
      we_q    <= we_i;
      wdata_q <= wdata_i;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (WAIT_CYC != 0);
  assign ready_o    = 1'b1;
  assign fire       = req_i;
  assign mem_addr   = addr_i;
  assign mem_be     = we_i;
  assign mem_wdata  = wdata_i;
`endif

  // Writes are suppressed under reset so an aborted access never lands in the array.
  assign mem_we = fire && (mem_be != 4'b0000) && !rst_i;
  assign mem_re = fire && (mem_be == 4'b0000);

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= mem_re;
      if (mem_re) rdata_q <= mem[mem_addr];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_sram_resp.sv
// Directed bench for dmem_sram_resp; wait-state scenarios are included when SRAM_WAIT_STATE_EN is defined.
module tb_dmem_sram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_sram_resp #(.ADDR_W(14), .WAIT_CYC(0)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata)
  );

`ifdef SRAM_WAIT_STATE_EN
  logic        w_req = 1'b0;
  logic [3:0]  w_we = 4'h0;
  logic [13:0] w_addr = '0;
  logic [31:0] w_wdata = '0;
  logic        ready2, rvalid2, ready3, rvalid3;
  logic [31:0] rdata2, rdata3;

  dmem_sram_resp #(.ADDR_W(14), .WAIT_CYC(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .req_i(w_req), .we_i(w_we), .addr_i(w_addr), .wdata_i(w_wdata),
    .ready_o(ready2), .rvalid_o(rvalid2), .rdata_o(rdata2)
  );

  dmem_sram_resp #(.ADDR_W(14), .WAIT_CYC(3)) dut_w3 (
    .clk_i(clk), .rst_i(rst), .req_i(w_req), .we_i(w_we), .addr_i(w_addr), .wdata_i(w_wdata),
    .ready_o(ready3), .rvalid_o(rvalid3), .rdata_o(rdata3)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [13:0] a, input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
  endtask

  task automatic test_full_write_read;
    drive(1'b1, 4'hF, 14'd5, 32'hDEADBEEF);
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b want 1", ready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL full_wr_no_valid: got %b want 0", rvalid); end
    drive(1'b1, 4'h0, 14'd5, 32'h0);
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL full_rd_valid: got %b want 1", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd_data: got %h want deadbeef", rdata); end
    drive(1'b0, 4'h0, 14'd0, 32'h0);
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL full_valid_pulse: got %b want 0", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rdata_hold: got %h want deadbeef", rdata); end
  endtask

  task automatic test_byte_enables;
    drive(1'b1, 4'hF, 14'd7, 32'h11223344);
    tick();
    drive(1'b1, 4'b0101, 14'd7, 32'hAABBCCDD);
    tick();
    drive(1'b1, 4'h0, 14'd7, 32'h0);
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL be_valid: got %b want 1", rvalid); end
    checks++; if (rdata !== 32'h11BB33DD) begin errors++; $display("FAIL be_data: got %h want 11bb33dd", rdata); end
    drive(1'b0, 4'h0, 14'd0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 14'(i), 32'(i + 1));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 14'(i), 32'h0);
      tick();
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, rvalid); end
      checks++; if (rdata !== 32'(i + 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, rdata, 32'(i + 1)); end
    end
    drive(1'b0, 4'h0, 14'd0, 32'h0);
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b want 0", rvalid); end
  endtask

  task automatic test_write_keeps_rdata;
    drive(1'b1, 4'hF, 14'd2, 32'h00000055);
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_keep_valid: got %b want 0", rvalid); end
    checks++; if (rdata !== 32'h00000003) begin errors++; $display("FAIL wr_keep_data: got %h want 00000003", rdata); end
    drive(1'b1, 4'h0, 14'd2, 32'h0);
    tick();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL wr_then_rd_valid: got %b want 1", rvalid); end
    checks++; if (rdata !== 32'h00000055) begin errors++; $display("FAIL wr_then_rd_data: got %h want 00000055", rdata); end
    drive(1'b0, 4'h0, 14'd0, 32'h0);
    tick();
  endtask

  task automatic test_async_reset;
    drive(1'b1, 4'hF, 14'd3, 32'h12345678);
    tick();
    drive(1'b1, 4'h0, 14'd3, 32'h0);
    tick();
    drive(1'b0, 4'h0, 14'd0, 32'h0);
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL arst_pre_data: got %h want 12345678", rdata); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", ready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL arst_rvalid: got %b want 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL arst_rdata: got %h want 00000000", rdata); end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef SRAM_WAIT_STATE_EN
  task automatic wait_idle;
    int n = 0;
    while (!(ready2 && ready3) && n < 20) begin tick(); n++; end
    checks++; if (!(ready2 && ready3)) begin errors++; $display("FAIL wait_idle_timeout: ready2=%b ready3=%b want 1 1", ready2, ready3); end
  endtask

  task automatic test_wait_state;
    w_req = 1'b1; w_we = 4'hF; w_addr = 14'd4; w_wdata = 32'hA5A50004;
    tick();
    w_req = 1'b0;
    wait_idle();
    w_req = 1'b1; w_we = 4'h0; w_addr = 14'd4; w_wdata = 32'h0;
    tick();
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL ws_ready_n1: got %b want 0", ready2); end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL ws_rvalid_n1: got %b want 0", rvalid2); end
    w_addr = 14'd6;
    tick();
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL ws_ready_n2: got %b want 0", ready2); end
    tick();
    w_req = 1'b0;
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL ws_ready_n3: got %b want 1", ready2); end
    checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL ws_rvalid_n3: got %b want 1", rvalid2); end
    checks++; if (rdata2 !== 32'hA5A50004) begin errors++; $display("FAIL ws_rdata_n3: got %h want a5a50004", rdata2); end
    tick();
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL ws_rvalid_n4: got %b want 0", rvalid2); end
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL ws_ignored_req: got ready %b want 1", ready2); end
    wait_idle();
  endtask

  task automatic test_wait_reset;
    int n = 0;
    w_req = 1'b1; w_we = 4'hF; w_addr = 14'd9; w_wdata = 32'h0;
    tick();
    w_req = 1'b0;
    wait_idle();
    w_req = 1'b1; w_we = 4'hF; w_addr = 14'd9; w_wdata = 32'hCAFEF00D;
    tick();
    w_req = 1'b0;
    checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL wr_rst_busy: got %b want 0", ready3); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL wr_rst_ready: got %b want 1", ready3); end
    checks++; if (rvalid3 !== 1'b0) begin errors++; $display("FAIL wr_rst_rvalid: got %b want 0", rvalid3); end
    tick();
    rst = 1'b0;
    tick();
    w_req = 1'b1; w_we = 4'h0; w_addr = 14'd9;
    tick();
    w_req = 1'b0;
    while (!rvalid3 && n < 20) begin tick(); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_rst_latency: got %0d extra cycles want 3", n); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL wr_rst_data: got %h want 00000000", rdata3); end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_enables();
    test_back_to_back();
    test_write_keeps_rdata();
    test_async_reset();
`ifdef SRAM_WAIT_STATE_EN
    test_wait_state();
    test_wait_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_sram_resp.md
# dmem_sram_resp

Responder end of the CPU data-memory port: accepts load/store requests issued by the MEM stage and answers them from an on-chip synchronous SRAM array with one cycle of read latency, matching the one-cycle-delay SRAM timing the pipeline is built around. Writes support per-byte enables; read data is registered and flagged with a single-cycle valid pulse. An optional wait-state mode stretches latency to exercise the pipeline's stall path.

## Interface
- ADDR_W, 14, word-address width; array depth = 2**ADDR_W words of 32 bits
- WAIT_CYC, 2, extra wait cycles per access (used only when SRAM_WAIT_STATE_EN is defined; legal 0..15)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req_i  input  1  request valid from MEM stage
- we_i  input  4  byte write enables, bit k covers wdata_i[8k+7:8k]; 4'b0000 = read
- addr_i  input  ADDR_W  word address
- wdata_i  input  32  store data
- ready_o  output  1  responder can accept a request this cycle
- rvalid_o  output  1  rdata_o holds the response to a read; one-cycle pulse
- rdata_o  output  32  read data, registered

## Operation
- Request accepted at a rising edge when req_i && ready_o.
- Write (we_i != 0): only enabled bytes of mem[addr_i] updated; disabled bytes unchanged. No rvalid_o pulse for writes.
- Read (we_i == 0): rdata_o <= mem[addr_i]; rvalid_o = 1 for exactly one cycle.
- rdata_o holds its last read value while rvalid_o = 0; not updated by writes.
- Read following a write to the same address sees the written data (write completes at acceptance edge, read samples array after it).
- Array contents are not reset; only control state and outputs are.
- req_i while ready_o = 0 is ignored; requester must hold req_i and all fields until accepted.
- Reset values: ready_o = 1, rvalid_o = 0, rdata_o = 32'h0; state IDLE.

## Timing
- Base mode: ready_o constantly 1. Read accepted at edge N -> rvalid_o = 1 and rdata_o valid during cycle N+1. Back-to-back requests every cycle supported; read latency 1, write latency 0 (visible at next access).
- Wait-state mode states: IDLE (ready_o = 1), WAIT (ready_o = 0, counter running).
- IDLE -> WAIT on acceptance if WAIT_CYC > 0; addr/we/wdata latched, counter loaded WAIT_CYC-1.
- WAIT: counter decrements each edge; at the edge where counter = 0, latched access performed (write or read into rdata_o), -> IDLE.
- Read accepted at edge N -> rvalid_o in cycle N+WAIT_CYC+1, coincident with ready_o returning to 1; a new request may be accepted at the end of that cycle.
- WAIT_CYC = 0 behaves exactly as base mode.
- Reset asserted mid-WAIT: immediate return to IDLE, pending access dropped (latched write never reaches the array), rvalid_o = 0.

## Configuration
- SRAM_WAIT_STATE_EN: when defined, the IDLE/WAIT FSM, request latches and wait counter are compiled in and latency follows WAIT_CYC. When undefined, no FSM or counter exists, ready_o is tied to 1, WAIT_CYC is ignored, and timing is the fixed one-cycle base mode.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle -> ready_o = 1, rvalid_o = 0, rdata_o = 0 immediately.
- Full write then read: write 32'hDEADBEEF we=4'hF addr 5 at edge N, read addr 5 at edge N+1 -> rvalid_o = 1, rdata_o = 32'hDEADBEEF in cycle N+2; rvalid_o = 0 in N+3.
- Byte enables: write 32'h11223344 we=4'hF addr 7, then 32'hAABBCCDD we=4'b0101, then read addr 7 -> rdata_o = 32'h11BB33DD.
- Streaming: reads of addr 0,1,2 on three consecutive edges (preloaded 1,2,3) -> rvalid_o high three consecutive cycles, rdata_o = 1,2,3.
- Wait-state (macro defined, WAIT_CYC=2): read accepted at edge N -> ready_o = 0 in N+1, N+2; rvalid_o = 1, ready_o = 1 in N+3; req_i pulses during N+1..N+2 with changed address ignored.
- Reset mid-operation (macro defined, WAIT_CYC=3): write 32'hCAFEF00D addr 9 over prior 32'h0, assert rst_i in first WAIT cycle, then read addr 9 -> rdata_o = 32'h0.
